// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster pixel stream into 2x2 pooling windows.
// Even rows are parked in a one-row line buffer. On odd rows each pixel pair
// is combined with the buffered pair above it to form one window. The window
// is presented on a valid/ready output and is held stable under backpressure.
module pool_window_gen #(
    parameter int OPERAND_WDTH = 19,
    parameter int NUM_PIXELS   = 2,
    parameter int IMG_WDTH     = 28,
    parameter int IMG_HGHT     = 28
) (
    input  logic                                     wgen_clk,
    input  logic                                     wgen_rst,
    input  logic [OPERAND_WDTH-1:0]                  pix_i,
    input  logic                                     pix_vld_i,
    output logic                                     pix_rdy_o,
    output logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  pool_a_o,
    output logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  pool_b_o,
    output logic                                     win_vld_o,
    input  logic                                     win_rdy_i,
    output logic                                     win_last_o
);

    localparam int CW = $clog2(IMG_WDTH);
    localparam int RW = $clog2(IMG_HGHT);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t                                   state_q;
    logic [CW-1:0]                            col_cnt_q;
    logic [CW-1:0]                            col_cnt_d;
    logic [RW-1:0]                            row_cnt_q;
    logic [RW-1:0]                            row_cnt_d;
    logic [OPERAND_WDTH-1:0]                  held_q;
    logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  pool_a_q;
    logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  pool_b_q;
    logic                                     win_vld_q;
    logic                                     win_last_q;
    logic [OPERAND_WDTH-1:0]                  linebuf_q [IMG_WDTH];

    logic                                     pix_acc_s;
    logic                                     last_col_s;
    logic                                     last_row_s;
    logic                                     load_win_s;
    logic [CW-1:0]                            rd_left_s;

    // A new pixel may enter whenever the output slot is empty or being drained.
    assign pix_rdy_o  = ~wgen_rst & (~win_vld_q | win_rdy_i);
    assign pix_acc_s  = pix_vld_i & pix_rdy_o;
    assign last_col_s = (col_cnt_q == CW'(IMG_WDTH - 1));
    assign last_row_s = (row_cnt_q == RW'(IMG_HGHT - 1));
    // Odd column of an odd row is the pixel that closes a 2x2 window.
    assign load_win_s = pix_acc_s & (state_q == ROW_ODD) & col_cnt_q[0];
    assign rd_left_s  = col_cnt_q - CW'(1);

    assign pool_a_o   = pool_a_q;
    assign pool_b_o   = pool_b_q;
    assign win_vld_o  = win_vld_q;
    assign win_last_o = win_last_q;

    // Column/row position of the next pixel; moves only on accepted pixels.
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (pix_acc_s) begin
            if (last_col_s) begin
                col_cnt_d = {CW{1'b0}};
                if (last_row_s) begin
                    row_cnt_d = {RW{1'b0}};
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                end
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
                row_cnt_d = row_cnt_q;
            end
        end else begin
            col_cnt_d = col_cnt_q;
            row_cnt_d = row_cnt_q;
        end
    end

    // Line buffer capture of even rows; contents are don't-care after reset.
    always_ff @(posedge wgen_clk) begin
        if (pix_acc_s && (state_q == ROW_EVEN)) begin
            linebuf_q[col_cnt_q] <= pix_i;
        end
    end

    // Row-parity FSM, counters, held-left pixel and the registered window output.
    always_ff @(posedge wgen_clk) begin
        if (wgen_rst) begin
            state_q    <= ROW_EVEN;
            col_cnt_q  <= {CW{1'b0}};
            row_cnt_q  <= {RW{1'b0}};
            held_q     <= {OPERAND_WDTH{1'b0}};
            pool_a_q   <= '0;
            pool_b_q   <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;

            if (pix_acc_s && last_col_s) begin
                case (state_q)
                    ROW_EVEN: state_q <= ROW_ODD;
                    ROW_ODD:  state_q <= ROW_EVEN;
                    default:  state_q <= ROW_EVEN;
                endcase
            end

            if (pix_acc_s && (state_q == ROW_ODD) && !col_cnt_q[0]) begin
                held_q <= pix_i;
            end

            // A freshly completed window takes priority over draining the old one.
            if (load_win_s) begin
                pool_a_q[0] <= linebuf_q[rd_left_s];
                pool_a_q[1] <= linebuf_q[col_cnt_q];
                pool_b_q[0] <= held_q;
                pool_b_q[1] <= pix_i;
                win_vld_q   <= 1'b1;
                win_last_q  <= last_col_s & last_row_s;
            end else if (win_vld_q && win_rdy_i) begin
                win_vld_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen on a 4x4 image, pixel = base+row*4+col.
// Expected windows are computed from pixel coordinates, queued when the
// completing pixel is driven, and popped when the DUT hands a window over.
module tb_pool_window_gen;

    localparam int OW = 19;
    localparam int NP = 2;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                     wgen_clk  = 1'b0;
    logic                     wgen_rst  = 1'b1;
    logic [OW-1:0]            pix_i     = '0;
    logic                     pix_vld_i = 1'b0;
    logic                     pix_rdy_o;
    logic [NP-1:0][OW-1:0]    pool_a_o;
    logic [NP-1:0][OW-1:0]    pool_b_o;
    logic                     win_vld_o;
    logic                     win_rdy_i = 1'b1;
    logic                     win_last_o;

    typedef struct {
        int a0;
        int a1;
        int b0;
        int b1;
        int last;
    } win_t;

    win_t sb_q[$];
    win_t mon_w;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_last = 0;
    int   mcol   = 0;
    int   mrow   = 0;

    pool_window_gen #(
        .OPERAND_WDTH (OW),
        .NUM_PIXELS   (NP),
        .IMG_WDTH     (W),
        .IMG_HGHT     (H)
    ) dut (
        .wgen_clk   (wgen_clk),
        .wgen_rst   (wgen_rst),
        .pix_i      (pix_i),
        .pix_vld_i  (pix_vld_i),
        .pix_rdy_o  (pix_rdy_o),
        .pool_a_o   (pool_a_o),
        .pool_b_o   (pool_b_o),
        .win_vld_o  (win_vld_o),
        .win_rdy_i  (win_rdy_i),
        .win_last_o (win_last_o)
    );

    always #5 wgen_clk = ~wgen_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one pixel at the current model position and wait until it is taken.
    task automatic send_pix(input int base, input bit gaps);
        int   k;
        bit   done;
        win_t w;
        k = 0;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            pix_vld_i = 1'b0;
            @(negedge wgen_clk);
        end
        pix_i     = OW'(base + mrow * W + mcol);
        pix_vld_i = 1'b1;
        while (pix_rdy_o !== 1'b1 && k < 100) begin
            @(negedge wgen_clk);
            k++;
        end
        if (k >= 100) begin
            chk("pix_accept_timeout", 32'(k), 0);
            pix_vld_i = 1'b0;
            return;
        end
        done = (mrow % 2 == 1) && (mcol % 2 == 1);
        if (done) begin
            w.a0   = base + (mrow - 1) * W + mcol - 1;
            w.a1   = base + (mrow - 1) * W + mcol;
            w.b0   = base + mrow * W + mcol - 1;
            w.b1   = base + mrow * W + mcol;
            w.last = int'((mrow == H - 1) && (mcol == W - 1));
            sb_q.push_back(w);
        end
        @(posedge wgen_clk);
        #1;
        chk("win_vld_latency", 32'(win_vld_o), int'(done));
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol = mcol + 1;
        end
        @(negedge wgen_clk);
    endtask

    task automatic send_n(input int base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_pix(base, gaps);
        end
    endtask

    task automatic drain_and_check(input string tag);
        pix_vld_i = 1'b0;
        repeat (3) @(negedge wgen_clk);
        chk(tag, 32'(sb_q.size()), 0);
    endtask

    // Output monitor: a window handed over on the coming edge is checked here.
    always @(negedge wgen_clk) begin
        if (!wgen_rst && win_vld_o === 1'b1 && win_rdy_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_window", 32'd1, 0);
            end else begin
                mon_w = sb_q.pop_front();
                chk("pool_a0",  32'(pool_a_o[0]), mon_w.a0);
                chk("pool_a1",  32'(pool_a_o[1]), mon_w.a1);
                chk("pool_b0",  32'(pool_b_o[0]), mon_w.b0);
                chk("pool_b1",  32'(pool_b_o[1]), mon_w.b1);
                chk("win_last", 32'(win_last_o),  mon_w.last);
                if (win_last_o === 1'b1) n_last++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge wgen_clk);
        chk("rst_pix_rdy",  32'(pix_rdy_o),   0);
        chk("rst_win_vld",  32'(win_vld_o),   0);
        chk("rst_win_last", 32'(win_last_o),  0);
        chk("rst_pool_a",   32'(pool_a_o[0] | pool_a_o[1]), 0);
        chk("rst_pool_b",   32'(pool_b_o[0] | pool_b_o[1]), 0);
        wgen_rst = 1'b0;
        @(negedge wgen_clk);

        // Streaming frame
        n_last = 0;
        send_n(0, 16, 1'b0);
        drain_and_check("stream_sb_empty");
        chk("stream_last_count", 32'(n_last), 1);

        // Backpressure: first window held for five cycles
        win_rdy_i = 1'b0;
        send_n(0, 6, 1'b0);
        pix_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_pix_rdy",  32'(pix_rdy_o),   0);
            chk("bp_win_vld",  32'(win_vld_o),   1);
            chk("bp_a0",       32'(pool_a_o[0]), 0);
            chk("bp_a1",       32'(pool_a_o[1]), 1);
            chk("bp_b0",       32'(pool_b_o[0]), 4);
            chk("bp_b1",       32'(pool_b_o[1]), 5);
            chk("bp_last",     32'(win_last_o),  0);
            @(negedge wgen_clk);
        end
        pix_vld_i = 1'b0;
        @(posedge wgen_clk);
        #2;
        win_rdy_i = 1'b1;
        send_n(0, 10, 1'b0);
        drain_and_check("bp_sb_empty");

        // Back-to-back frames
        n_last = 0;
        send_n(0, 16, 1'b0);
        send_n(16, 16, 1'b0);
        drain_and_check("b2b_sb_empty");
        chk("b2b_last_count", 32'(n_last), 2);

        // Random input gaps
        send_n(0, 16, 1'b1);
        drain_and_check("gaps_sb_empty");

        // Reset mid-frame after pixel 6
        send_n(0, 7, 1'b0);
        pix_vld_i = 1'b0;
        wgen_rst  = 1'b1;
        @(posedge wgen_clk);
        #1;
        chk("mrst_win_vld",  32'(win_vld_o),  0);
        chk("mrst_win_last", 32'(win_last_o), 0);
        chk("mrst_pool_a",   32'(pool_a_o[0] | pool_a_o[1]), 0);
        chk("mrst_pool_b",   32'(pool_b_o[0] | pool_b_o[1]), 0);
        chk("mrst_pix_rdy",  32'(pix_rdy_o),  0);
        @(negedge wgen_clk);
        wgen_rst = 1'b0;
        mcol = 0;
        mrow = 0;
        chk("mrst_sb_empty", 32'(sb_q.size()), 0);
        sb_q.delete();
        @(negedge wgen_clk);
        n_last = 0;
        send_n(0, 16, 1'b0);
        drain_and_check("post_rst_sb_empty");
        chk("post_rst_last_count", 32'(n_last), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 Parameters:
- OPERAND_WDTH, default 19, pixel width in bits.
- NUM_PIXELS, default 2, pixels per window row; fixed at 2.
- IMG_WDTH, default 28, pixels per input row; even, >= 2.
- IMG_HGHT, default 28, rows per frame; even, >= 2.
REQ-002 Ports (name, direction, width, meaning):
- wgen_clk  in  1  clock; the only clock.
- wgen_rst  in  1  reset; synchronous, active-high.
- pix_i  in  OPERAND_WDTH  raster-order input pixel.
- pix_vld_i  in  1  pix_i valid.
- pix_rdy_o  out  1  block accepts pix_i.
- pool_a_o  out  [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  upper window row; [0]=left, [1]=right.
- pool_b_o  out  [NUM_PIXELS-1:0][OPERAND_WDTH-1:0]  lower window row; [0]=left, [1]=right.
- win_vld_o  out  1  window valid.
- win_rdy_i  in  1  downstream (max_pool stage) accepts window.
- win_last_o  out  1  window is the last of the frame; qualified by win_vld_o.

Function
REQ-003 Pixel acceptance: a pixel is accepted on a rising edge with pix_vld_i && pix_rdy_o.
REQ-004 Window acceptance: a window is accepted on a rising edge with win_vld_o && win_rdy_i.
REQ-005 pix_rdy_o = ~wgen_rst & (~win_vld_o | win_rdy_i), combinational.
REQ-006 Counters col_cnt (0..IMG_WDTH-1) and row_cnt (0..IMG_HGHT-1) advance only on accepted pixels.
- col_cnt wraps to 0 after IMG_WDTH-1, and row_cnt then increments.
- row_cnt wraps to 0 after IMG_HGHT-1 (frame wrap), with no gap cycle.
REQ-007 FSM has two states, ROW_EVEN and ROW_ODD.
- Reset state is ROW_EVEN.
- On acceptance of the last column, the state toggles.
REQ-008 ROW_EVEN: each accepted pixel is written to line buffer entry col_cnt (IMG_WDTH x OPERAND_WDTH). No window is produced.
REQ-009 ROW_ODD, even col_cnt: the accepted pixel is stored in the held-left register.
REQ-010 ROW_ODD, odd col_cnt: the accepted pixel c completes a window. On the next edge, the block registers:
- pool_a_o[0] = linebuf[c-1], pool_a_o[1] = linebuf[c].
- pool_b_o[0] = held-left, pool_b_o[1] = pix_i.
- win_vld_o = 1.
REQ-011 Latency is exactly 1 cycle, from the edge accepting the completing pixel to win_vld_o high.
REQ-012 win_last_o = 1 with a window iff the completing pixel had row_cnt = IMG_HGHT-1 and col_cnt = IMG_WDTH-1; otherwise 0.
REQ-013 Output hold: while win_vld_o && ~win_rdy_i, pool_a_o, pool_b_o and win_last_o hold stable and no pixel is accepted.
REQ-014 win_vld_o clears on window acceptance unless a new window is loaded on the same edge.
- Simultaneous accept plus load: the outputs take the new window and win_vld_o stays 1.
REQ-015 Line buffer entries read in REQ-010 were written in the immediately preceding ROW_EVEN row. The buffer is never read and written in the same state.
REQ-016 Output rate: each frame yields exactly (IMG_WDTH/2)*(IMG_HGHT/2) windows, in raster order of window position.
REQ-017 pix_vld_i deasserted mid-row or mid-frame: the block stalls in place, with no state change and no output change other than draining a pending window.

Reset
REQ-018 While wgen_rst=1 at a rising edge, the next state is:
- win_vld_o=0, win_last_o=0, pool_a_o=0, pool_b_o=0.
- col_cnt=0, row_cnt=0, held-left=0, FSM=ROW_EVEN.
REQ-019 Line buffer contents are not reset. Their values are don't-care until rewritten.
REQ-020 Reset asserted mid-frame: any partial frame and any pending window are discarded. The first pixel accepted after reset is treated as row 0, column 0.
REQ-021 pix_rdy_o=0 while wgen_rst=1.

Verification
Bench parameters: IMG_WDTH=4, IMG_HGHT=4, pixel value = row*4+col.
REQ-022 Streaming case: 16 pixels, pix_vld_i=1 continuously, win_rdy_i=1.
- Windows (a0,a1,b0,b1): (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
- Each appears 1 cycle after pixels 5, 7, 13, 15 respectively.
- win_last_o=1 only on the 4th window.
REQ-023 Backpressure: win_rdy_i=0 for 5 cycles after the first window.
- (0,1,4,5) holds stable and pix_rdy_o=0 throughout.
- After release, the remaining three windows arrive intact, in order.
REQ-024 Back-to-back frames: two consecutive 16-pixel frames.
- Second-frame windows equal the first-frame windows + 16 per element.
- win_last_o is set twice, once per frame.
REQ-025 Input gaps: random pix_vld_i duty of 50%. Window values and order match REQ-022 exactly.
REQ-026 Reset mid-operation: wgen_rst pulsed after pixel 6 of a frame.
- Outputs are zero and win_vld_o=0 next cycle.
- A fresh 16-pixel frame then yields exactly the REQ-022 windows.
